enc_iter_core: RTL and testbench

ENC_ITER_CORE -- requirements
Module: enc_iter_core

---
 rtl/enc_iter_core.sv | 140 ++++++++++++++
 tb/tb_enc_iter_core.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_iter_core.sv
// -----------------------------------------------------------------------------
// enc_iter_core
//   Iterative SPN block cipher core. It computes one round per clock: a layer
//   of 3-bit S-boxes, a 2-bit left rotation and a key mix with a round key
//   derived on the fly from the previous one. The final round key is also
//   returned so that a caller can chain blocks.
//
// Parameters
//   N_SBOX  number of 3-bit S-box lanes (>= 2); W = 3*N_SBOX
//   ROUNDS  number of rounds (1..255)
//
// Ports
//   clk        sole clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   Din/Key offered this cycle
//   in_ready   core is idle and takes Din/Key on this edge
//   Din, Key   plaintext and initial key K0 (W bits each)
//   out_valid  Dout/key_out hold a finished result
//   out_ready  downstream takes the result on this edge
//   Dout       ciphertext (registered)
//   key_out    final round key K_ROUNDS (registered)
//   busy       rounds are being computed
// -----------------------------------------------------------------------------
module enc_iter_core #(
  parameter int N_SBOX = 4,
  parameter int ROUNDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*N_SBOX-1:0] Din,
  input  logic [3*N_SBOX-1:0] Key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3*N_SBOX-1:0] Dout,
  output logic [3*N_SBOX-1:0] key_out,
  output logic                busy
);

  localparam int W  = 3 * N_SBOX;
  localparam int CW = ($clog2(ROUNDS + 1) < 1) ? 1 : $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [W-1:0]    data_reg;
  logic [W-1:0]    key_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    dout_reg;
  logic [W-1:0]    kout_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            busy_reg;

  logic [W-1:0]    sub_next;
  logic [W-1:0]    spn_next;
  logic [W-1:0]    key_next;
  logic [W-1:0]    data_next;

  // S-box layer: o0 = x0, o1 = ~x1, o2 = ~x1 ^ x0 ^ x2 on every lane
  for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_sbox
    assign sub_next[3*gi]   = data_reg[3*gi];
    assign sub_next[3*gi+1] = ~data_reg[3*gi+1];
    assign sub_next[3*gi+2] = ~data_reg[3*gi+1] ^ data_reg[3*gi] ^ data_reg[3*gi+2];
  end

  // Rotate the substituted word left by two bits
  assign spn_next  = {sub_next[W-3:0], sub_next[W-1:W-2]};
  // Round key schedule: k ^ ~rotl(k,1)
  assign key_next  = key_reg ^ ~{key_reg[W-2:0], key_reg[W-1]};
  assign data_next = spn_next ^ key_next;

  // The counter reaching ROUNDS marks that every round is done; that extra
  // RUN cycle copies the state into the output registers, so the outputs
  // only change when a result is published.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      key_reg       <= '0;
      cnt_reg       <= '0;
      dout_reg      <= '0;
      kout_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg     <= Din ^ Key;
            key_reg      <= Key;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_reg == CW'(ROUNDS)) begin
            dout_reg      <= data_reg;
            kout_reg      <= key_reg;
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            data_reg <= data_next;
            key_reg  <= key_next;
            cnt_reg  <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign Dout      = dout_reg;
  assign key_out   = kout_reg;

endmodule

// File: tb/tb_enc_iter_core.sv
// -----------------------------------------------------------------------------
// tb_enc_iter_core
//   Nine instances of enc_iter_core cover N_SBOX in {2,4,8} x ROUNDS in
//   {1,2,7}. Instance index k: N_SBOX from k/3, ROUNDS from k%3. Instance 4 is
//   the default (4,2) build, instance 3 is (4,1). Known vectors, corner-case
//   sequences and random traffic are checked against a bit-level model.
// -----------------------------------------------------------------------------
module tb_enc_iter_core;

  localparam int NCFG = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a     [NCFG];
  logic        in_valid_a  [NCFG];
  logic        out_ready_a [NCFG];
  logic [23:0] din_a       [NCFG];
  logic [23:0] key_a       [NCFG];
  logic        in_ready_a  [NCFG];
  logic        out_valid_a [NCFG];
  logic        busy_a      [NCFG];
  logic [23:0] dout_a      [NCFG];
  logic [23:0] kout_a      [NCFG];

  int errors = 0;
  int checks = 0;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int NS = (gi / 3 == 0) ? 2 : ((gi / 3 == 1) ? 4 : 8);
    localparam int RS = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 7);
    localparam int W  = 3 * NS;
    logic [W-1:0] dout_w;
    logic [W-1:0] kout_w;
    logic         rdy_w;
    logic         ov_w;
    logic         busy_w;

    enc_iter_core #(.N_SBOX(NS), .ROUNDS(RS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n_a[gi]),
      .in_valid  (in_valid_a[gi]),
      .in_ready  (rdy_w),
      .Din       (din_a[gi][W-1:0]),
      .Key       (key_a[gi][W-1:0]),
      .out_valid (ov_w),
      .out_ready (out_ready_a[gi]),
      .Dout      (dout_w),
      .key_out   (kout_w),
      .busy      (busy_w)
    );

    assign in_ready_a[gi]  = rdy_w;
    assign out_valid_a[gi] = ov_w;
    assign busy_a[gi]      = busy_w;
    assign dout_a[gi]      = 24'(dout_w);
    assign kout_a[gi]      = 24'(kout_w);
  end

  // ---------------- configuration helpers ----------------
  function automatic int ns_of(int k);
    return (k / 3 == 0) ? 2 : ((k / 3 == 1) ? 4 : 8);
  endfunction
  function automatic int rs_of(int k);
    return (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 2 : 7);
  endfunction
  function automatic int w_of(int k);
    return 3 * ns_of(k);
  endfunction
  function automatic logic [23:0] mask_w(int w);
    logic [23:0] one;
    one = 24'd1;
    return (one << w) - 24'd1;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [23:0] m_rotl(logic [23:0] x, int n, int w);
    logic [23:0] y;
    y = '0;
    for (int j = 0; j < w; j++) y[(j + n) % w] = x[j];
    return y;
  endfunction

  function automatic logic [23:0] m_sub(logic [23:0] x, int w);
    logic [23:0] y;
    int v;
    int o;
    y = '0;
    for (int l = 0; l < w / 3; l++) begin
      v = int'(x[3*l +: 3]);
      // o0 = x0, o1 = not x1, o2 = not x1 xor x0 xor x2
      o = (v & 1)
        + (((v >> 1) & 1) ^ 1) * 2
        + ((((v >> 1) & 1) ^ 1) ^ (v & 1) ^ ((v >> 2) & 1)) * 4;
      y[3*l +: 3] = 3'(o);
    end
    return y;
  endfunction

  function automatic logic [23:0] m_ka(logic [23:0] k, int w);
    return (k ^ ~m_rotl(k, 1, w)) & mask_w(w);
  endfunction

  task automatic m_encrypt(input logic [23:0] din, input logic [23:0] key, input int w,
                           input int rounds, output logic [23:0] dout, output logic [23:0] kout);
    logic [23:0] s;
    logic [23:0] kk;
    s  = din ^ key;
    kk = key;
    for (int r = 1; r <= rounds; r++) begin
      kk = m_ka(kk, w);
      s  = m_rotl(m_sub(s, w), 2, w) ^ kk;
    end
    dout = s & mask_w(w);
    kout = kk;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // From a negedge after a transfer edge: count rising edges until out_valid
  // is seen. Optionally keeps toggling in_valid/Din/Key to prove they are ignored.
  task automatic wait_out(input int k, input bit noise, output int lat, output bit got);
    logic [23:0] m;
    m   = mask_w(w_of(k));
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      in_valid_a[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      din_a[k]      = 24'($urandom) & m;
      key_a[k]      = 24'($urandom) & m;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_a[k]) got = 1'b1;
    end
    chk_int("out_valid_timeout", int'(got), 1);
  endtask

  // Complete the output handshake and confirm the core is back in IDLE.
  task automatic finish_hs(input int k);
    in_valid_a[k]  = 1'b0;
    out_ready_a[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_a[k] = 1'b0;
    chk("ready_after_hs", 24'(in_ready_a[k]), 24'd1);
    chk("valid_after_hs", 24'(out_valid_a[k]), 24'd0);
  endtask

  // One full transaction with `stall` cycles of back-pressure in DONE.
  task automatic run_txn(input int k, input logic [23:0] din, input logic [23:0] key,
                         input logic [23:0] exp_d, input logic [23:0] exp_k,
                         input int stall, input bit noise);
    int lat;
    bit got;
    logic [23:0] m;
    m = mask_w(w_of(k));
    @(negedge clk);
    chk("ready_before", 24'(in_ready_a[k]), 24'd1);
    in_valid_a[k]  = 1'b1;
    din_a[k]       = din;
    key_a[k]       = key;
    out_ready_a[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("busy_in_run", 24'(busy_a[k]), 24'd1);
    chk("ready_in_run", 24'(in_ready_a[k]), 24'd0);
    wait_out(k, noise, lat, got);
    chk_int("latency", lat, rs_of(k) + 1);
    chk("dout", dout_a[k], exp_d);
    chk("key_out", kout_a[k], exp_k);
    chk("busy_in_done", 24'(busy_a[k]), 24'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid_a[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      din_a[k]      = 24'($urandom) & m;
      key_a[k]      = 24'($urandom) & m;
      @(posedge clk);
      @(negedge clk);
      chk("hold_dout", dout_a[k], exp_d);
      chk("hold_key_out", kout_a[k], exp_k);
      chk("hold_valid", 24'(out_valid_a[k]), 24'd1);
      chk("ready_in_done", 24'(in_ready_a[k]), 24'd0);
    end
    finish_hs(k);
    $display("txn cfg=%0d din=%h key=%h dout=%h key_out=%h lat=%0d stall=%0d",
             k, din, key, dout_a[k], kout_a[k], lat, stall);
  endtask

  typedef struct {
    int          k;
    logic [23:0] din;
    logic [23:0] key;
    logic [23:0] exp_d;
    logic [23:0] exp_k;
    int          stall;
  } vec_t;

  vec_t tab [5];

  initial begin
    int lat;
    bit got;
    logic [23:0] ed;
    logic [23:0] ek;
    logic [23:0] rd;
    logic [23:0] rk;

    tab[0] = '{k: 4, din: 24'hD5B, key: 24'hACD, exp_d: 24'hE32, exp_k: 24'hE04, stall: 0};
    tab[1] = '{k: 3, din: 24'hD5B, key: 24'hACD, exp_d: 24'hCBB, exp_k: 24'h0A9, stall: 1};
    tab[2] = '{k: 4, din: 24'h000, key: 24'h000, exp_d: 24'hDB6, exp_k: 24'hFFF, stall: 2};
    tab[3] = '{k: 3, din: 24'h000, key: 24'h000, exp_d: 24'h924, exp_k: 24'hFFF, stall: 0};
    tab[4] = '{k: 4, din: 24'hD5B, key: 24'hACD, exp_d: 24'hE32, exp_k: 24'hE04, stall: 5};

    for (int k = 0; k < NCFG; k++) begin
      rst_n_a[k]     = 1'b0;
      in_valid_a[k]  = 1'b0;
      out_ready_a[k] = 1'b0;
      din_a[k]       = '0;
      key_a[k]       = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 24'(in_ready_a[4]), 24'd1);
    chk("rst_out_valid", 24'(out_valid_a[4]), 24'd0);
    chk("rst_busy", 24'(busy_a[4]), 24'd0);
    chk("rst_dout", dout_a[4], 24'd0);
    chk("rst_key_out", kout_a[4], 24'd0);

    // Transfer on the very first edge after reset release
    for (int k = 0; k < NCFG; k++) rst_n_a[k] = 1'b1;
    in_valid_a[4] = 1'b1;
    din_a[4]      = 24'hD5B;
    key_a[4]      = 24'hACD;
    @(posedge clk);
    @(negedge clk);
    chk("first_edge_busy", 24'(busy_a[4]), 24'd1);
    wait_out(4, 1'b0, lat, got);
    chk_int("first_latency", lat, 3);
    chk("first_dout", dout_a[4], 24'hE32);
    finish_hs(4);

    // Known-answer table (last row stalls 5 cycles with toggling inputs)
    for (int i = 0; i < 5; i++)
      run_txn(tab[i].k, tab[i].din, tab[i].key, tab[i].exp_d, tab[i].exp_k,
              tab[i].stall, (tab[i].stall >= 5));

    // Reset one cycle after a transfer discards the operation
    @(negedge clk);
    in_valid_a[4] = 1'b1;
    din_a[4]      = 24'h123;
    key_a[4]      = 24'h456;
    @(posedge clk);
    @(negedge clk);
    in_valid_a[4] = 1'b0;
    rst_n_a[4]    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n_a[4] = 1'b1;
    chk("midrst_in_ready", 24'(in_ready_a[4]), 24'd1);
    chk("midrst_out_valid", 24'(out_valid_a[4]), 24'd0);
    chk("midrst_busy", 24'(busy_a[4]), 24'd0);
    chk("midrst_dout", dout_a[4], 24'd0);
    chk("midrst_key_out", kout_a[4], 24'd0);
    run_txn(4, 24'hD5B, 24'hACD, 24'hE32, 24'hE04, 0, 1'b0);

    // Reset while DONE with out_ready asserted: reset wins
    @(negedge clk);
    in_valid_a[4] = 1'b1;
    din_a[4]      = 24'hD5B;
    key_a[4]      = 24'hACD;
    @(posedge clk);
    @(negedge clk);
    wait_out(4, 1'b0, lat, got);
    rst_n_a[4]     = 1'b0;
    out_ready_a[4] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n_a[4]     = 1'b1;
    out_ready_a[4] = 1'b0;
    chk("donerst_out_valid", 24'(out_valid_a[4]), 24'd0);
    chk("donerst_dout", dout_a[4], 24'd0);
    chk("donerst_in_ready", 24'(in_ready_a[4]), 24'd1);

    // Back-to-back: in_valid held high, out_ready held high
    @(negedge clk);
    out_ready_a[4] = 1'b1;
    in_valid_a[4]  = 1'b1;
    din_a[4]       = 24'hD5B;
    key_a[4]       = 24'hACD;
    @(posedge clk);
    @(negedge clk);
    din_a[4] = 24'h000;
    key_a[4] = 24'h000;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_a[4]) got = 1'b1;
    end
    chk_int("b2b_a_latency", lat, 3);
    chk("b2b_a_dout", dout_a[4], 24'hE32);
    chk("b2b_a_key_out", kout_a[4], 24'hE04);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_ready", 24'(in_ready_a[4]), 24'd1);
    chk("b2b_idle_valid", 24'(out_valid_a[4]), 24'd0);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_a[4]) got = 1'b1;
    end
    chk_int("b2b_b_latency", lat, 4);
    chk("b2b_b_dout", dout_a[4], 24'hDB6);
    chk("b2b_b_key_out", kout_a[4], 24'hFFF);
    $display("txn cfg=4 b2b second dout=%h key_out=%h", dout_a[4], kout_a[4]);
    in_valid_a[4] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready_a[4] = 1'b0;
    chk("b2b_end_ready", 24'(in_ready_a[4]), 24'd1);

    // Random traffic on every configuration against the model
    for (int k = 0; k < NCFG && errors < 40; k++) begin
      for (int n = 0; n < 112 && errors < 40; n++) begin
        rd = 24'($urandom) & mask_w(w_of(k));
        rk = 24'($urandom) & mask_w(w_of(k));
        m_encrypt(rd, rk, w_of(k), rs_of(k), ed, ek);
        run_txn(k, rd, rk, ed, ek, $urandom_range(0, 3), 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
